// File: rtl/ycbcr_pkg.sv
// Shared constants and types for the BT.601 studio-range YCbCr -> RGB converter.
// Coefficients are 8.8 fixed point (value * 256).
package ycbcr_pkg;

  localparam int SUM_W = 20;

  localparam int Y_OFS = 16;
  localparam int K_Y   = 298;
  localparam int K_RCR = 409;
  localparam int K_GCB = 100;
  localparam int K_GCR = 208;
  localparam int K_BCB = 516;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic        [7:0] y;
    logic signed [7:0] cb;
    logic signed [7:0] cr;
  } ycbcr_t;

  // Sign-extend the 9-bit offset luma to the product width
  function automatic logic signed [SUM_W-1:0] sext9(input logic signed [8:0] v);
    return {{(SUM_W-9){v[8]}}, v};
  endfunction

  // Sign-extend an 8-bit chroma sample to the product width
  function automatic logic signed [SUM_W-1:0] sext8(input logic signed [7:0] v);
    return {{(SUM_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/ycbcr2rgb_clamp.sv
// Combinational round-and-clamp of one 8.8 colour sum to an 8-bit channel.
// sat_o flags that the rounded value fell outside 0..255.
module ycbcr2rgb_clamp
  import ycbcr_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum_i,
  output logic        [7:0]       val_o,
  output logic                    sat_o
);

  localparam logic signed [SUM_W-1:0] RND_BIAS = SUM_W'(128);

  // Round to nearest (half up) and drop the 8 fraction bits, keeping the sign
  function automatic logic signed [SUM_W-1:0] round8(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] t;
    t = s + RND_BIAS;
    return t >>> 8;
  endfunction

  logic signed [SUM_W-1:0] rnd;

  // Negative results go to 0, anything with bits above bit 7 goes to 255
  always_comb begin
    rnd   = round8(sum_i);
    val_o = rnd[7:0];
    sat_o = 1'b0;
    if (rnd[SUM_W-1]) begin
      val_o = 8'd0;
      sat_o = 1'b1;
    end else if (|rnd[SUM_W-2:8]) begin
      val_o = 8'd255;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/ycbcr2rgb.sv
// BT.601 studio-range YCbCr -> 8-bit RGB, 3-stage pipeline with valid/ready.
//   p0: offset luma and the five coefficient products
//   p1: per-channel sums
//   p2: rounded/clamped RGB (the output register)
// Whole pipeline advances together on adv = !out_valid || out_ready.
// Optional feature: define YCBCR2RGB_SAT_CNT_EN to get the sat_cnt port,
// a saturating count of output transfers in which any channel was clamped.
module ycbcr2rgb
  import ycbcr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] Y,
  input  logic [7:0] Cb,
  input  logic [7:0] Cr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
`ifdef YCBCR2RGB_SAT_CNT_EN
  ,
  output logic [15:0] sat_cnt
`endif
);

  localparam logic signed [SUM_W-1:0] KY_S   = SUM_W'(K_Y);
  localparam logic signed [SUM_W-1:0] KRCR_S = SUM_W'(K_RCR);
  localparam logic signed [SUM_W-1:0] KGCB_S = SUM_W'(K_GCB);
  localparam logic signed [SUM_W-1:0] KGCR_S = SUM_W'(K_GCR);
  localparam logic signed [SUM_W-1:0] KBCB_S = SUM_W'(K_BCB);
  localparam logic signed [8:0]       YOFS_S = 9'(Y_OFS);

  logic adv;

  ycbcr_t            pix;
  logic signed [8:0] yo;

  logic signed [SUM_W-1:0] y_p0_d, rcr_p0_d, gcb_p0_d, gcr_p0_d, bcb_p0_d;
  logic signed [SUM_W-1:0] y_p0_q, rcr_p0_q, gcb_p0_q, gcr_p0_q, bcb_p0_q;
  logic                    vld_p0_q;

  logic signed [SUM_W-1:0] r_p1_d, g_p1_d, b_p1_d;
  logic signed [SUM_W-1:0] r_p1_q, g_p1_q, b_p1_q;
  logic                    vld_p1_q;

  rgb_t rgb_p2_d, rgb_p2_q;
  logic vld_p2_q;
  logic sat_r, sat_g, sat_b;

  // A full output register that is not being drained freezes the whole pipe
  assign adv      = !vld_p2_q || out_ready;
  assign in_ready = adv;

  // ---- stage p0: remove black level, form coefficient products ----
  assign pix = {Y, Cb, Cr};
  assign yo  = $signed({1'b0, pix.y}) - YOFS_S;

  assign y_p0_d   = KY_S   * sext9(yo);
  assign rcr_p0_d = KRCR_S * sext8(pix.cr);
  assign gcb_p0_d = KGCB_S * sext8(pix.cb);
  assign gcr_p0_d = KGCR_S * sext8(pix.cr);
  assign bcb_p0_d = KBCB_S * sext8(pix.cb);

  // Product registers, loaded on every advance
  always_ff @(posedge clk) begin
    if (adv) begin
      y_p0_q   <= y_p0_d;
      rcr_p0_q <= rcr_p0_d;
      gcb_p0_q <= gcb_p0_d;
      gcr_p0_q <= gcr_p0_d;
      bcb_p0_q <= bcb_p0_d;
    end
  end

  // ---- stage p1: channel sums ----
  assign r_p1_d = y_p0_q + rcr_p0_q;
  assign g_p1_d = y_p0_q - gcb_p0_q - gcr_p0_q;
  assign b_p1_d = y_p0_q + bcb_p0_q;

  // Sum registers, loaded on every advance
  always_ff @(posedge clk) begin
    if (adv) begin
      r_p1_q <= r_p1_d;
      g_p1_q <= g_p1_d;
      b_p1_q <= b_p1_d;
    end
  end

  // ---- stage p2: round and clamp each channel ----
  ycbcr2rgb_clamp u_clamp_r (.sum_i(r_p1_q), .val_o(rgb_p2_d.r), .sat_o(sat_r));
  ycbcr2rgb_clamp u_clamp_g (.sum_i(g_p1_q), .val_o(rgb_p2_d.g), .sat_o(sat_g));
  ycbcr2rgb_clamp u_clamp_b (.sum_i(b_p1_q), .val_o(rgb_p2_d.b), .sat_o(sat_b));

  // Valid bits travel with their data; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (adv) begin
      vld_p0_q <= in_valid;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  // Output colour register, cleared so R/G/B read 0 during and after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2_q <= '0;
    end else if (adv) begin
      rgb_p2_q <= rgb_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign R         = rgb_p2_q.r;
  assign G         = rgb_p2_q.g;
  assign B         = rgb_p2_q.b;

`ifdef YCBCR2RGB_SAT_CNT_EN
  logic        sat_p2_q;
  logic [15:0] sat_cnt_q;

  // Clamp flag rides alongside the output pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_p2_q <= 1'b0;
    end else if (adv) begin
      sat_p2_q <= sat_r | sat_g | sat_b;
    end
  end

  // Count clamped pixels as they leave; sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= 16'd0;
    end else if (vld_p2_q && out_ready && sat_p2_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat = sat_r | sat_g | sat_b;
`endif

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Scoreboard bench for ycbcr2rgb: the stimulus side pushes expected pixels,
// an independent monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_ycbcr2rgb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] Y = '0, Cb = '0, Cr = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] R, G, B;
`ifdef YCBCR2RGB_SAT_CNT_EN
  logic [15:0] sat_cnt;
  int          exp_sat_cnt = 0;
`endif

  always #5 clk = ~clk;

  ycbcr2rgb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Y        (Y),
    .Cb       (Cb),
    .Cr       (Cr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .R        (R),
    .G        (G),
    .B        (B)
`ifdef YCBCR2RGB_SAT_CNT_EN
    ,
    .sat_cnt  (sat_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          rand_ready = 1'b0;
  bit          stalled = 1'b0;
  logic [23:0] held = '0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic s);
    return {r, g, b, s};
  endfunction

  // Reference: the BT.601 equations in plain integer arithmetic
  function automatic exp_t model(input int y, input int cb, input int cr);
    int   ys;
    int   ch[3];
    int   v[3];
    logic s;
    ys    = 298 * (y - 16);
    ch[0] = ys + 409 * cr;
    ch[1] = ys - 100 * cb - 208 * cr;
    ch[2] = ys + 516 * cb;
    s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v[i] = (ch[i] + 128) >>> 8;
      if (v[i] < 0) begin
        v[i] = 0;
        s = 1'b1;
      end else if (v[i] > 255) begin
        v[i] = 255;
        s = 1'b1;
      end
    end
    return {8'(v[0]), 8'(v[1]), 8'(v[2]), s};
  endfunction

  // Present one pixel (called just after a posedge); returns just after its transfer edge
  task automatic send(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr, input exp_t e);
    bit acc = 1'b0;
    Y = y; Cb = cb; Cr = cr; in_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
    end
    if (acc) exp_q.push_back(e);
    else begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    int yv, cbv, crv;
    yv  = $urandom_range(0, 255);
    cbv = $urandom_range(0, 255);
    crv = $urandom_range(0, 255);
    cbv = cbv - 128;
    crv = crv - 128;
    send(8'(yv), 8'(cbv), 8'(crv), model(yv, cbv, crv));
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: always 1, or random when backpressure is enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: handshake rule, stall stability, ordered output comparison
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        check("in_ready_adv", in_ready, !out_valid || out_ready);
        if (stalled) begin
          check("stall_valid", out_valid, 1);
          check("stall_hold", {R, G, B}, held);
        end
`ifdef YCBCR2RGB_SAT_CNT_EN
        check("sat_cnt", sat_cnt, exp_sat_cnt);
`endif
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got %0h expected no output at %0t", {R, G, B}, $time);
          end else begin
            mon_e = exp_q.pop_front();
            check("rgb", {R, G, B}, {mon_e.r, mon_e.g, mon_e.b});
`ifdef YCBCR2RGB_SAT_CNT_EN
            if (mon_e.sat && exp_sat_cnt < 65535) exp_sat_cnt++;
`endif
          end
        end
        stalled = out_valid && !out_ready;
        held    = {R, G, B};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_rgb", {R, G, B}, 0);
`ifdef YCBCR2RGB_SAT_CNT_EN
    check("reset_sat_cnt", sat_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Black, with latency observed on an empty pipe
    send(8'd16, 8'h00, 8'h00, mk(8'd0, 8'd0, 8'd0, 1'b0));
    @(negedge clk); check("latency_1", out_valid, 0);
    @(negedge clk); check("latency_2", out_valid, 0);
    @(negedge clk); check("latency_3", out_valid, 1);
    @(posedge clk); #1;

    // White, pure red, and the two extremes
    send(8'd235, 8'h00, 8'h00, mk(8'd255, 8'd255, 8'd255, 1'b0));
    send(8'd81,  8'hDA, 8'd111, mk(8'd253, 8'd0, 8'd0, 1'b1));
    send(8'd255, 8'h7F, 8'h7F, mk(8'd255, 8'd125, 8'd255, 1'b1));
    send(8'd0,   8'h80, 8'h80, mk(8'd0, 8'd135, 8'd0, 1'b1));
    drain();
`ifdef YCBCR2RGB_SAT_CNT_EN
    check("sat_cnt_directed", sat_cnt, 3);
`endif

    // Backpressure: 8 back-to-back pixels, then a longer stream with gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_rand();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send_rand();
    end
    drain();
    rand_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Reset with three pixels in flight
    send_rand();
    send_rand();
    send_rand();
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_rgb", {R, G, B}, 0);
`ifdef YCBCR2RGB_SAT_CNT_EN
    check("midreset_sat_cnt", sat_cnt, 0);
    exp_sat_cnt = 0;
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'd128, 8'h10, 8'hF0, model(128, 16, -16));
    drain();
    repeat (4) @(negedge clk);
    check("post_reset_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
